uart_word_tx: RTL

- Drain stage directly downstream of the logger FIFO.
- Pops 32-bit logged words from the FIFO read port and serialises each one as 4 UART 8N1 frames on a single tx line, least-significant byte first.
- Runs continuously while enabled and the FIFO is non-empty; provides a busy flag and a sent-word counter for status registers.

---
 rtl/uart_word_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: pops 32-bit words from a FIFO and sends each as four UART frames on tx.
// Optional even-parity bit per frame when UART_TX_PARITY_EN is defined (8E1 instead of 8N1).
module uart_word_tx #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int MSB_BYTE_FIRST = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_rd_data,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, LATCH = 3'd2, START = 3'd3,
        DATA = 3'd4, PARITY = 3'd5, STOP = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, LATCH = 3'd2, START = 3'd3,
        DATA = 3'd4, STOP = 3'd6
    } state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t            state_r, state_s;
    logic [15:0]       baud_r, baud_s;
    logic [2:0]        bit_r, bit_s;
    logic [1:0]        byte_r, byte_s;
    logic [31:0]       word_r, word_s;
    logic [CNT_W-1:0]  words_r, words_s;
    logic              tx_r, tx_s;
    logic              rd_en_r, rd_en_s;
    logic              busy_r, busy_s;
    logic              bit_end_s;
    logic [1:0]        sel_s;
    logic [7:0]        cur_byte_s;

    // Next-state sequencing of fetch, frame bits and byte index
    always_comb begin
        state_s   = state_r;
        bit_s     = bit_r;
        byte_s    = byte_r;
        word_s    = word_r;
        words_s   = words_r;
        bit_end_s = (baud_r == BAUD_LAST);
        case (state_r)
            IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: state_s = LATCH;
            LATCH: begin
                word_s  = fifo_rd_data;
                byte_s  = 2'd0;
                state_s = START;
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    bit_s   = 3'd0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_s = PARITY;
`else
                    state_s = STOP;
`endif
                end else if (bit_end_s) begin
                    bit_s = bit_r + 3'd1;
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s && (byte_r != 2'd3)) begin
                    byte_s  = byte_r + 2'd1;
                    state_s = START;
                end else if (bit_end_s) begin
                    words_s = words_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (tx_enable && !fifo_empty) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Baud counter restarts on every state entry and at every bit boundary
    always_comb begin
        if ((state_s != state_r) || bit_end_s) begin
            baud_s = 16'd0;
        end else begin
            baud_s = baud_r + 16'd1;
        end
    end

    // Output values for the coming cycle, derived from the next state so outputs can be registered
    always_comb begin
        sel_s      = (MSB_BYTE_FIRST != 0) ? (2'd3 - byte_s) : byte_s;
        cur_byte_s = word_s[{sel_s, 3'b000} +: 8];
        rd_en_s    = (state_s == FETCH);
        busy_s     = (state_s != IDLE);
        case (state_s)
            START:  tx_s = 1'b0;
            DATA:   tx_s = cur_byte_s[bit_s];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_s = even_parity(cur_byte_s);
`endif
            default: tx_s = 1'b1;
        endcase
    end

    // State and output registers; reset drops the current word and idles the line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            baud_r  <= 16'd0;
            bit_r   <= 3'd0;
            byte_r  <= 2'd0;
            word_r  <= 32'd0;
            words_r <= {CNT_W{1'b0}};
            tx_r    <= 1'b1;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
            word_r  <= word_s;
            words_r <= words_s;
            tx_r    <= tx_s;
            rd_en_r <= rd_en_s;
            busy_r  <= busy_s;
        end
    end

    assign tx         = tx_r;
    assign fifo_rd_en = rd_en_r;
    assign busy       = busy_r;
    assign words_sent = words_r;

endmodule
